game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Upstream control stage for the background renderer.
- Synchronises and debounces the two game push-buttons, latches press events, and advances a game-state FSM.
- Drives the 3-bit state code `state` consumed by the renderer's S input.
- State updates only on the frame-done pulse from the VGA timing generator, so a frame is never drawn with two different states.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised button level must hold before it is accepted (10 ms at 50 MHz); legal range >=1.
- READY_FRAMES, 120, frames spent in READY before PLAY; legal range 1..255.
- OVER_FRAMES, 240, frames in OVER before auto-return to ATTRACT (used only with the optional feature); legal range 1..255.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  asynchronous active-low reset.
- btn_n  input  2  raw KEY levels, active-low, asynchronous; bit0 = start, bit1 = pause.
- frame_done  input  1  one-cycle pulse from the VGA timing generator at end of visible frame.
- game_over  input  1  level from gameplay logic; sampled only on frame_done.
- state  output  3  current game state code, feeds renderer S.
- state_changed  output  1  one-cycle pulse in the cycle `state` takes a new value.
- btn_held  output  2  debounced button-down level, active-high.
- btn_press  output  2  one-cycle pulse per accepted press.

Behaviour:
- Reset (rst=0, async), all registers cleared/initialised: sync flops=1, stable=1, debounce counters=0, pend=0, frame_cnt=0, state=ATTRACT(3'd0), state_changed=0, btn_held=0, btn_press=0.
- Synchroniser: 2 flops per button.
- Debounce, per button:
  - If synced != stable, counter increments; otherwise counter clears.
  - When counter reaches DEBOUNCE_CYCLES-1 while still differing, stable <= synced and counter clears.
  - Net effect: stable changes after exactly DEBOUNCE_CYCLES consecutive differing samples; any glitch shorter than that is rejected.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
- btn_held = ~stable.
- btn_press[i] is a registered pulse, high for one cycle in the cycle after stable[i] falls 1->0. Releases produce no pulse.
- Event latch: pend[i] sets on btn_press[i] and is cleared on frame_done.
- FSM input on frame_done is ev = pend | btn_press, so a press coincident with frame_done is consumed at that boundary, not lost.
- Multiple presses within one frame collapse to one event.
- FSM: evaluated only in cycles with frame_done=1; the registered update is visible the next cycle, with state_changed=1 in that same cycle if the code differs.
  - ATTRACT(0): ev.start -> READY, frame_cnt<=0. Pause ignored.
  - READY(1): frame_cnt increments per frame; when frame_cnt==READY_FRAMES-1 -> PLAY, frame_cnt<=0. Both events ignored.
  - PLAY(2): game_over=1 -> OVER, frame_cnt<=0 (highest priority). Otherwise ev.pause -> PAUSE.
  - PAUSE(3): ev.pause or ev.start -> PLAY. game_over ignored.
  - OVER(4): ev.start -> ATTRACT.
  - Codes 5..7: unreachable; forced to ATTRACT on the next frame_done.
- frame_cnt is 8 bits, saturates at 255, and clears on every state transition.
- frame_done asserted on consecutive cycles is treated as consecutive frames; no special filtering.
- A reset mid-frame or mid-debounce returns everything to reset values immediately. A button held through reset release is accepted after DEBOUNCE_CYCLES+2 cycles.

Optional Feature:
- ATTRACT_TIMEOUT_EN, when defined:
  - In OVER, frame_cnt increments per frame.
  - When frame_cnt==OVER_FRAMES-1 -> ATTRACT, unless ev.start occurs first; start has priority and gives the same destination.
- When not defined: OVER exits only on ev.start, frame_cnt is unused in OVER, and OVER_FRAMES is ignored.

Test Plan (DEBOUNCE_CYCLES=4, READY_FRAMES=3, OVER_FRAMES=2, frame_done every 20 clk):
- Reset, then hold btn_n=2'b11 for 200 clk -> state=0, btn_held=0, btn_press=0, state_changed never 1.
- btn_n[0] low for 3 clk then high (glitch) -> no btn_press. Low for 10 clk -> btn_press[0] single pulse exactly 2+4+1 clk after the falling edge; btn_held[0]=1 until 6 clk after release.
- Start press -> state 0->1 at next frame_done+1; after 3 further frame_done -> state=2; state_changed pulses once per transition.
- In PLAY, pause press and game_over=1 at the same frame_done -> state=4 (game_over wins); pend cleared.
- In PAUSE, start press coincident with frame_done -> state=2 on the following cycle. Two pause presses within one frame -> single toggle only.
- In OVER, no presses: with ATTRACT_TIMEOUT_EN -> state=0 after 2 frames; without -> stays 4 for 10 frames, then a start press -> 0. Mid-test rst=0 -> state=0 asynchronously, without waiting for a clk edge.

Source files
------------

// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the game control stage, its button/VGA sources and the renderer.
// The master side drives the raw inputs; the controller sits on the slave side.
interface game_state_ctrl_if;
   logic [1:0] btn_n;
   logic       frame_done;
   logic       game_over;
   logic [2:0] state;
   logic       state_changed;
   logic [1:0] btn_held;
   logic [1:0] btn_press;

   modport master (
      output btn_n, frame_done, game_over,
      input  state, state_changed, btn_held, btn_press
   );

   modport slave (
      input  btn_n, frame_done, game_over,
      output state, state_changed, btn_held, btn_press
   );
endinterface

// File: rtl/game_state_ctrl.sv
// Button synchroniser/debouncer and frame-aligned game-state FSM feeding the renderer.
// Optional ATTRACT_TIMEOUT_EN: OVER auto-returns to ATTRACT after OVER_FRAMES frames.
module game_state_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int READY_FRAMES    = 120,
   parameter int OVER_FRAMES     = 240
) (
   input logic              clk,
   input logic              rst,
   game_state_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_ATTRACT = 3'd0,
      ST_READY   = 3'd1,
      ST_PLAY    = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_OVER    = 3'd4
   } state_e;

   localparam int            CW         = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]    READY_LAST = 8'(READY_FRAMES - 1);
`ifdef ATTRACT_TIMEOUT_EN
   localparam logic [7:0]    OVER_LAST  = 8'(OVER_FRAMES - 1);
`endif

   if (DEBOUNCE_CYCLES < 1 || READY_FRAMES < 1 || READY_FRAMES > 255 ||
       OVER_FRAMES < 1 || OVER_FRAMES > 255) begin : g_bad_params
      $error("game_state_ctrl: parameter out of legal range");
   end

   logic [1:0]         sync1_q, sync1_d;
   logic [1:0]         sync2_q, sync2_d;
   logic [1:0]         stable_q, stable_d;
   logic [1:0]         stable_dly_q, stable_dly_d;
   logic [1:0][CW-1:0] dbc_q, dbc_d;
   logic [1:0]         btn_press_q, btn_press_d;
   logic [1:0]         pend_q, pend_d;
   logic [1:0]         ev;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   state_e             state_q, state_d;
   logic               state_changed_q, state_changed_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      sync1_d      = bus.btn_n;
      sync2_d      = sync1_q;
      stable_d     = stable_q;
      dbc_d        = dbc_q;
      stable_dly_d = stable_q;

      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (dbc_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
               dbc_d[i]    = '0;
            end else begin
               dbc_d[i] = dbc_q[i] + CW'(1);
            end
         end else begin
            dbc_d[i] = '0;
         end
      end

      // Press pulse lands one cycle after the debounced level falls.
      btn_press_d = stable_dly_q & ~stable_q;

      // A press arriving together with frame_done is consumed at that boundary.
      ev     = pend_q | btn_press_q;
      pend_d = bus.frame_done ? 2'b00 : ev;

      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      if (bus.frame_done) begin
         frame_cnt_d = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
         case (state_q)
            ST_ATTRACT: if (ev[0]) state_d = ST_READY;
            ST_READY:   if (frame_cnt_q == READY_LAST) state_d = ST_PLAY;
            ST_PLAY: begin
               if (bus.game_over)  state_d = ST_OVER;
               else if (ev[1])     state_d = ST_PAUSE;
            end
            ST_PAUSE:   if (|ev) state_d = ST_PLAY;
            ST_OVER: begin
               if (ev[0]) state_d = ST_ATTRACT;
`ifdef ATTRACT_TIMEOUT_EN
               else if (frame_cnt_q == OVER_LAST) state_d = ST_ATTRACT;
`endif
            end
            default:    state_d = ST_ATTRACT;
         endcase
         if (state_d != state_q) frame_cnt_d = 8'd0;
      end

      state_changed_d = (state_d != state_q);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q         <= 2'b11;
         sync2_q         <= 2'b11;
         stable_q        <= 2'b11;
         stable_dly_q    <= 2'b11;
         dbc_q           <= '0;
         btn_press_q     <= 2'b00;
         pend_q          <= 2'b00;
         frame_cnt_q     <= 8'd0;
         state_q         <= ST_ATTRACT;
         state_changed_q <= 1'b0;
      end else begin
         sync1_q         <= sync1_d;
         sync2_q         <= sync2_d;
         stable_q        <= stable_d;
         stable_dly_q    <= stable_dly_d;
         dbc_q           <= dbc_d;
         btn_press_q     <= btn_press_d;
         pend_q          <= pend_d;
         frame_cnt_q     <= frame_cnt_d;
         state_q         <= state_d;
         state_changed_q <= state_changed_d;
      end
   end

   assign bus.state         = state_q;
   assign bus.state_changed = state_changed_q;
   assign bus.btn_held      = ~stable_q;
   assign bus.btn_press     = btn_press_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Randomised bench for game_state_ctrl against a cycle-level behavioural model of the
// button acceptance rules and the frame-driven game flow.
module tb_game_state_ctrl;
   localparam int DB = 4;
   localparam int RF = 3;
   localparam int OF = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;

   game_state_ctrl_if gif ();

   game_state_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .READY_FRAMES   (RF),
      .OVER_FRAMES    (OF)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(gif.slave)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: raw levels two edges old are the samples a button is judged on.
   logic [1:0] raw_prev, raw_prev2;
   bit         m_level[2];
   int         m_run[2];
   bit         m_fell[2];
   bit [1:0]   m_press;
   bit [1:0]   m_pend;
   int         m_state;
   int         m_frames;
   bit         m_changed;

   task automatic model_reset();
      raw_prev  = 2'b11;
      raw_prev2 = 2'b11;
      for (int i = 0; i < 2; i++) begin
         m_level[i] = 1'b1;
         m_run[i]   = 0;
         m_fell[i]  = 1'b0;
      end
      m_press   = '0;
      m_pend    = '0;
      m_state   = 0;
      m_frames  = 0;
      m_changed = 1'b0;
   endtask

   task automatic model_step(input logic [1:0] raw, input bit fd, input bit go);
      bit [1:0] ev;
      bit [1:0] smp;
      bit [1:0] new_press;
      int       nxt;
      ev        = m_pend | m_press;
      smp       = raw_prev2;
      raw_prev2 = raw_prev;
      raw_prev  = raw;

      nxt = m_state;
      if (fd) begin
         case (m_state)
            0: if (ev[0]) nxt = 1;
            1: if (m_frames == RF - 1) nxt = 2;
            2: begin
               if (go)         nxt = 4;
               else if (ev[1]) nxt = 3;
            end
            3: if (ev != 2'b00) nxt = 2;
            4: begin
               if (ev[0]) nxt = 0;
`ifdef ATTRACT_TIMEOUT_EN
               else if (m_frames == OF - 1) nxt = 0;
`endif
            end
            default: nxt = 0;
         endcase
         if (nxt != m_state) m_frames = 0;
         else if (m_frames < 255) m_frames++;
      end
      m_changed = (nxt != m_state);
      m_state   = nxt;
      m_pend    = fd ? 2'b00 : ev;

      // A level is accepted after DB consecutive samples that disagree with the current one.
      for (int i = 0; i < 2; i++) begin
         new_press[i] = m_fell[i];
         m_fell[i]    = 1'b0;
         if (smp[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_level[i] = smp[i];
               m_run[i]   = 0;
               m_fell[i]  = (smp[i] == 1'b0);
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_press = new_press;
   endtask

   function automatic logic [1:0] exp_held();
      return {~m_level[1], ~m_level[0]};
   endfunction

   task automatic check_all(input string when_tag);
      check({when_tag, "_state"},   8'(gif.state),         8'(m_state));
      check({when_tag, "_changed"}, 8'(gif.state_changed), 8'(m_changed));
      check({when_tag, "_held"},    8'(gif.btn_held),      8'(exp_held()));
      check({when_tag, "_press"},   8'(gif.btn_press),     8'(m_press));
   endtask

   int       hold_left[2];
   logic [1:0] lvl;
   int       fd_gap;
   bit       rst_done;

   initial begin
      gif.btn_n      = 2'b11;
      gif.frame_done = 1'b0;
      gif.game_over  = 1'b0;
      lvl            = 2'b11;
      hold_left[0]   = 40;
      hold_left[1]   = 60;
      fd_gap         = 10;
      rst_done       = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      rst = 1'b1;

      for (int cyc = 0; cyc < 6000; cyc++) begin
         // One asynchronous reset in the middle of activity, checked before any clock edge.
         if (!rst_done && cyc >= 3000 && (m_state != 0 || cyc >= 4000)) begin
            #2 rst = 1'b0;
            #1;
            model_reset();
            check_all("async_rst");
            rst_done = 1'b1;
            @(negedge clk);
            rst = 1'b1;
         end

         for (int i = 0; i < 2; i++) begin
            if (hold_left[i] == 0) begin
               lvl[i]       = ~lvl[i];
               hold_left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                         : int'($urandom_range(4, 30));
            end else begin
               hold_left[i]--;
            end
         end
         gif.btn_n = lvl;

         if (fd_gap == 0) begin
            gif.frame_done = 1'b1;
            fd_gap         = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(3, 20));
         end else begin
            gif.frame_done = 1'b0;
            fd_gap--;
         end
         gif.game_over = ($urandom_range(0, 5) == 0);

         @(posedge clk);
         model_step(gif.btn_n, gif.frame_done, gif.game_over);
         #1;
         check_all("run");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
